// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - decode, writeback-request and register-file write-port bundle
interface regfile_wb_arbiter_if #(
    parameter int N_REQ = 3
);
    logic                  issue_valid;
    logic [4:0]            issue_dst;
    logic                  issue_ready;
    logic [4:0]            rs_addr;
    logic [4:0]            rt_addr;
    logic                  stall_rs;
    logic                  stall_rt;
    logic [N_REQ-1:0]      req_valid;
    logic [5*N_REQ-1:0]    req_addr;
    logic [32*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  rf_wr;
    logic [4:0]            rf_addr;
    logic [31:0]           rf_data;

    modport master (
        output issue_valid, issue_dst, rs_addr, rt_addr, req_valid, req_addr, req_data,
        input  issue_ready, stall_rs, stall_rt, req_ready, rf_wr, rf_addr, rf_data
    );

    modport slave (
        input  issue_valid, issue_dst, rs_addr, rt_addr, req_valid, req_addr, req_data,
        output issue_ready, stall_rs, stall_rt, req_ready, rf_wr, rf_addr, rf_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with pending-write scoreboard
// WB_RR_EN selects round-robin arbitration; fixed priority (index 0 first) otherwise.
module regfile_wb_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [31:1]      pend;
    logic [31:1]      pend_nxt;
    logic [31:0]      pend_vec;
    logic             gnt_any;
    logic [PW-1:0]    gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic [4:0]       gnt_addr;
    logic [31:0]      gnt_data;
    logic             rf_wr_q;
    logic [4:0]       rf_addr_q;
    logic [31:0]      rf_data_q;

    // Bit 0 is a constant zero so $0 never reads as pending.
    assign pend_vec        = {pend, 1'b0};
    assign bus.issue_ready = ~reset & ~pend_vec[bus.issue_dst];
    assign bus.stall_rs    = ~reset & pend_vec[bus.rs_addr];
    assign bus.stall_rt    = ~reset & pend_vec[bus.rt_addr];

`ifdef WB_RR_EN
    logic [PW-1:0] ptr;

    always_comb begin
        int cand;
        cand    = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr) + 1 + i) % N_REQ;
            if (!gnt_any && bus.req_valid[PW'(cand)]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PW'(N_REQ - 1);
        end else if (gnt_any) begin
            ptr <= gnt_idx;
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[PW'(i)]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(i);
            end
        end
    end
`endif

    always_comb begin
        gnt = '0;
        if (gnt_any && !reset) begin
            gnt[gnt_idx] = 1'b1;
        end
        gnt_addr = bus.req_addr[int'(gnt_idx) * 5 +: 5];
        gnt_data = bus.req_data[int'(gnt_idx) * 32 +: 32];
    end

    assign bus.req_ready = gnt;

    // Issue and clear never target the same bit: a pending register blocks its own issue.
    always_comb begin
        pend_nxt = pend;
        if (rf_wr_q && rf_addr_q != 5'd0) begin
            pend_nxt[rf_addr_q] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_ready && bus.issue_dst != 5'd0) begin
            pend_nxt[bus.issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend      <= '0;
            rf_wr_q   <= 1'b0;
            rf_addr_q <= 5'd0;
            rf_data_q <= 32'd0;
        end else begin
            pend <= pend_nxt;
            if (gnt_any) begin
                rf_wr_q   <= (gnt_addr != 5'd0);
                rf_addr_q <= gnt_addr;
                rf_data_q <= gnt_data;
            end else begin
                rf_wr_q <= 1'b0;
            end
        end
    end

    assign bus.rf_wr   = rf_wr_q;
    assign bus.rf_addr = rf_addr_q;
    assign bus.rf_data = rf_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   vec = 0;
    int   errs = 0;

    regfile_wb_arbiter_if #(.N_REQ(3)) bus ();

    regfile_wb_arbiter #(.N_REQ(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle inputs/outputs away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.req_valid[k]          = v;
        bus.req_addr[5*k +: 5]    = a;
        bus.req_data[32*k +: 32]  = d;
    endtask

    task automatic clear_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_dst   = 5'd0;
        bus.rs_addr     = 5'd0;
        bus.rt_addr     = 5'd0;
        bus.req_valid   = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        bus.req_valid   = 3'b111;
        bus.issue_valid = 1'b1;
        bus.issue_dst   = 5'd5;
        bus.rs_addr     = 5'd5;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            vec++; if (bus.req_ready !== 3'b000) begin errs++; $display("FAIL reset_req_ready: got %b want 000", bus.req_ready); end
            vec++; if (bus.rf_wr !== 1'b0) begin errs++; $display("FAIL reset_rf_wr: got %b want 0", bus.rf_wr); end
            vec++; if (bus.issue_ready !== 1'b0) begin errs++; $display("FAIL reset_issue_ready: got %b want 0", bus.issue_ready); end
        end
        clear_inputs();
        reset = 1'b0;
        tick();
        bus.rs_addr = 5'd5;
        bus.rt_addr = 5'd31;
        #1;
        vec++; if (bus.stall_rs !== 1'b0) begin errs++; $display("FAIL reset_pend_rs5: got %b want 0", bus.stall_rs); end
        vec++; if (bus.stall_rt !== 1'b0) begin errs++; $display("FAIL reset_pend_rt31: got %b want 0", bus.stall_rt); end
        vec++; if (bus.rf_addr !== 5'd0 || bus.rf_data !== 32'd0) begin errs++; $display("FAIL reset_rf_regs: got %0d/%h want 0/0", bus.rf_addr, bus.rf_data); end
    endtask

    task automatic test_issue_write();
        clear_inputs();
        bus.issue_valid = 1'b1;
        bus.issue_dst   = 5'd5;
        bus.rs_addr     = 5'd5;
        #1;
        vec++; if (bus.issue_ready !== 1'b1) begin errs++; $display("FAIL iw_issue_ready: got %b want 1", bus.issue_ready); end
        vec++; if (bus.stall_rs !== 1'b0) begin errs++; $display("FAIL iw_stall_before: got %b want 0", bus.stall_rs); end
        tick();
        bus.issue_valid = 1'b0;
        set_req(0, 1'b1, 5'd5, 32'h1234_5678);
        #1;
        vec++; if (bus.stall_rs !== 1'b1) begin errs++; $display("FAIL iw_stall_pending: got %b want 1", bus.stall_rs); end
        vec++; if (bus.req_ready !== 3'b001) begin errs++; $display("FAIL iw_grant: got %b want 001", bus.req_ready); end
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        #1;
        vec++; if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd5 || bus.rf_data !== 32'h1234_5678) begin
            errs++; $display("FAIL iw_rf_write: got %b/%0d/%h want 1/5/12345678", bus.rf_wr, bus.rf_addr, bus.rf_data); end
        vec++; if (bus.stall_rs !== 1'b1) begin errs++; $display("FAIL iw_stall_t1: got %b want 1", bus.stall_rs); end
        tick();
        #1;
        vec++; if (bus.stall_rs !== 1'b0) begin errs++; $display("FAIL iw_stall_t2: got %b want 0", bus.stall_rs); end
        vec++; if (bus.rf_wr !== 1'b0 || bus.rf_data !== 32'h1234_5678) begin errs++; $display("FAIL iw_rf_idle: got %b/%h want 0/12345678", bus.rf_wr, bus.rf_data); end
    endtask

    task automatic test_waw();
        clear_inputs();
        bus.issue_valid = 1'b1;
        bus.issue_dst   = 5'd7;
        bus.rt_addr     = 5'd7;
        tick();
        set_req(1, 1'b1, 5'd7, 32'hAAAA_0007);
        #1;
        vec++; if (bus.issue_ready !== 1'b0) begin errs++; $display("FAIL waw_hold0: got %b want 0", bus.issue_ready); end
        vec++; if (bus.req_ready !== 3'b010) begin errs++; $display("FAIL waw_grant1: got %b want 010", bus.req_ready); end
        tick();
        set_req(1, 1'b0, 5'd0, 32'd0);
        #1;
        vec++; if (bus.issue_ready !== 1'b0) begin errs++; $display("FAIL waw_hold_at_write: got %b want 0", bus.issue_ready); end
        vec++; if (bus.rf_wr !== 1'b1 || bus.rf_addr !== 5'd7) begin errs++; $display("FAIL waw_rf: got %b/%0d want 1/7", bus.rf_wr, bus.rf_addr); end
        tick();
        #1;
        vec++; if (bus.issue_ready !== 1'b1) begin errs++; $display("FAIL waw_release: got %b want 1", bus.issue_ready); end
        tick();
        bus.issue_valid = 1'b0;
        set_req(2, 1'b1, 5'd7, 32'hBBBB_0007);
        #1;
        vec++; if (bus.stall_rt !== 1'b1) begin errs++; $display("FAIL waw_reissued: got %b want 1", bus.stall_rt); end
        vec++; if (bus.req_ready !== 3'b100) begin errs++; $display("FAIL waw_grant2: got %b want 100", bus.req_ready); end
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);
        tick();
        #1;
        vec++; if (bus.stall_rt !== 1'b0) begin errs++; $display("FAIL waw_cleared: got %b want 0", bus.stall_rt); end
    endtask

    task automatic test_contention();
        logic [2:0] exp_g;
        logic [4:0] prev_addr;
        clear_inputs();
        for (int k = 0; k < 3; k++) set_req(k, 1'b1, 5'(10 + k), 32'hC000_0000 + 32'(k));
        prev_addr = 5'd0;
        for (int c = 0; c < 6; c++) begin
`ifdef WB_RR_EN
            exp_g = 3'b001 << (c % 3);
`else
            exp_g = 3'b001;
`endif
            #1;
            vec++; if (bus.req_ready !== exp_g) begin errs++; $display("FAIL cont_grant%0d: got %b want %b", c, bus.req_ready, exp_g); end
            if (c > 0) begin
                vec++; if (bus.rf_wr !== 1'b1 || bus.rf_addr !== prev_addr) begin
                    errs++; $display("FAIL cont_rf%0d: got %b/%0d want 1/%0d", c, bus.rf_wr, bus.rf_addr, prev_addr); end
            end
            prev_addr = (exp_g == 3'b001) ? 5'd10 : (exp_g == 3'b010) ? 5'd11 : 5'd12;
            tick();
        end
        clear_inputs();
        #1;
        vec++; if (bus.rf_addr !== prev_addr || bus.rf_data !== 32'hC000_0000 + 32'(prev_addr - 5'd10)) begin
            errs++; $display("FAIL cont_last: got %0d/%h want %0d", bus.rf_addr, bus.rf_data, prev_addr); end
        tick();
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        set_req(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        bus.issue_valid = 1'b1;
        bus.issue_dst   = 5'd0;
        #1;
        vec++; if (bus.req_ready !== 3'b001) begin errs++; $display("FAIL zero_grant: got %b want 001", bus.req_ready); end
        vec++; if (bus.issue_ready !== 1'b1) begin errs++; $display("FAIL zero_issue_ready: got %b want 1", bus.issue_ready); end
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        #1;
        vec++; if (bus.rf_wr !== 1'b0) begin errs++; $display("FAIL zero_no_write: got %b want 0", bus.rf_wr); end
        vec++; if (bus.stall_rs !== 1'b0 || bus.issue_ready !== 1'b1) begin
            errs++; $display("FAIL zero_no_stall: got stall=%b ready=%b want 0/1", bus.stall_rs, bus.issue_ready); end
        bus.issue_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midop();
        clear_inputs();
        bus.issue_valid = 1'b1;
        bus.issue_dst   = 5'd9;
        bus.rs_addr     = 5'd9;
        tick();
        bus.issue_valid = 1'b0;
        set_req(0, 1'b1, 5'd9, 32'h0000_0999);
        #1;
        vec++; if (bus.stall_rs !== 1'b1) begin errs++; $display("FAIL mid_pending: got %b want 1", bus.stall_rs); end
        reset = 1'b1;
        #1;
        vec++; if (bus.req_ready !== 3'b000 || bus.stall_rs !== 1'b0) begin
            errs++; $display("FAIL mid_reset_comb: got %b/%b want 000/0", bus.req_ready, bus.stall_rs); end
        tick();
        #1;
        vec++; if (bus.rf_wr !== 1'b0) begin errs++; $display("FAIL mid_rf_wr: got %b want 0", bus.rf_wr); end
        reset = 1'b0;
        set_req(0, 1'b0, 5'd0, 32'd0);
        tick();
        #1;
        vec++; if (bus.stall_rs !== 1'b0 || bus.rf_wr !== 1'b0) begin
            errs++; $display("FAIL mid_discarded: got stall=%b wr=%b want 0/0", bus.stall_rs, bus.rf_wr); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_issue_write();
        test_waw();
        test_contention();
        test_zero_reg();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
